// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Modulo-n increment of an index, used to rotate round-robin priority.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: first requester at or after rr_ptr, with wrap.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             found,
    output logic [ID_W-1:0]  winner
);

    localparam int SUM_W = ID_W + 1;

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [ID_W-1:0]    offset;
    logic [SUM_W-1:0]   sum;

    // Rotate the doubled request vector so rr_ptr lands on bit 0, then take
    // the lowest set bit and map its offset back to an absolute index.
    always_comb begin
        dbl    = {req, req} >> rr_ptr;
        rot    = dbl[N_REQ-1:0];
        found  = |rot;
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = ID_W'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= SUM_W'(N_REQ)) begin
            sum = sum - SUM_W'(N_REQ);
        end
        winner = sum[ID_W-1:0];
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 4,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [WIDTH-1:0]     data [N_REQ],
    output logic [N_REQ-1:0]     grant,
    input  logic                 fifo_full,
    output logic                 fifo_write_request,
    output logic [WIDTH-1:0]     fifo_data_in,
    output logic [ID_W-1:0]      fifo_src_id,
    output logic                 busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic             pick_found;
    logic [ID_W-1:0]  pick_winner;
    logic             gnt_valid;
    logic [ID_W-1:0]  gnt_id;
    logic [CNT_W-1:0] cnt_inc;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .winner (pick_winner)
    );

    // Arbitration state register; reset aborts any burst and restores priority to producer 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state and grant decision; a full FIFO or reset suppresses any write.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt_valid   = 1'b0;
        gnt_id      = '0;
        cnt_inc     = burst_cnt_q + CNT_W'(1);

        if (!reset && !fifo_full) begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        gnt_valid   = 1'b1;
                        gnt_id      = pick_winner;
                        owner_d     = pick_winner;
                        burst_cnt_d = CNT_W'(1);
                        if (MAX_BURST == 1) begin
                            rr_ptr_d = ID_W'(next_idx(32'(pick_winner), N_REQ));
                        end else begin
                            state_d = BURST;
                        end
                    end
                end
                BURST: begin
                    if (req[owner_q]) begin
                        gnt_valid   = 1'b1;
                        gnt_id      = owner_q;
                        burst_cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(MAX_BURST)) begin
                            state_d  = IDLE;
                            rr_ptr_d = ID_W'(next_idx(32'(owner_q), N_REQ));
                        end
                    end else begin
                        // Owner withdrew mid-burst: spend one bubble releasing the lock.
                        state_d  = IDLE;
                        rr_ptr_d = ID_W'(next_idx(32'(owner_q), N_REQ));
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output mux: everything is zero unless a write is issued this cycle.
    always_comb begin
        grant              = '0;
        fifo_write_request = gnt_valid;
        fifo_data_in       = '0;
        fifo_src_id        = '0;
        busy               = (state_q == BURST) && !reset;
        if (gnt_valid) begin
            grant        = N_REQ'(1) << gnt_id;
            fifo_data_in = data[gnt_id];
            fifo_src_id  = gnt_id;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized scoreboard bench for fifo_write_arbiter.
module tb_fifo_write_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [W-1:0] data [N];
    logic [N-1:0] grant;
    logic         fifo_full = 1'b0;
    logic         fifo_write_request;
    logic [W-1:0] fifo_data_in;
    logic [1:0]   fifo_src_id;
    logic         busy;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic       wr;
        logic [1:0] id;
        logic [7:0] dat;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_writes = 0;
    int dut_writes = 0;

    // Reference model: who owns the port, how many writes it has done,
    // and which producer is first in line.
    bit   m_locked = 0;
    int   m_owner = 0;
    int   m_cnt = 0;
    int   m_ptr = 0;
    logic [W-1:0] pdata [N];

    fifo_write_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req                (req),
        .data               (data),
        .grant              (grant),
        .fifo_full          (fifo_full),
        .fifo_write_request (fifo_write_request),
        .fifo_data_in       (fifo_data_in),
        .fifo_src_id        (fifo_src_id),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // One clock of stimulus: drive inputs, predict outputs, queue the prediction.
    task automatic cycle(input logic [N-1:0] r, input logic f, input logic rs,
                         output logic wr, output int id);
        exp_t e;
        int   w;
        bit   fnd;
        @(posedge clk);
        #1;
        req       = r;
        fifo_full = f;
        reset     = rs;
        for (int i = 0; i < N; i++) data[i] = pdata[i];

        e.cyc  = cyc;
        e.gnt  = '0;
        e.wr   = 1'b0;
        e.id   = '0;
        e.dat  = '0;
        e.busy = !rs && m_locked;
        w      = -1;

        if (rs) begin
            m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        end else if (!f) begin
            if (!m_locked) begin
                fnd = 0;
                for (int k = 0; k < N; k++) begin
                    if (!fnd && r[(m_ptr + k) % N]) begin
                        fnd = 1;
                        w = (m_ptr + k) % N;
                    end
                end
                if (fnd) begin
                    m_owner = w;
                    m_cnt = 1;
                    if (MB == 1) m_ptr = (w + 1) % N;
                    else m_locked = 1;
                end
            end else if (r[m_owner]) begin
                w = m_owner;
                m_cnt++;
                if (m_cnt == MB) begin
                    m_locked = 0;
                    m_ptr = (m_owner + 1) % N;
                end
            end else begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % N;
            end
        end

        if (w >= 0) begin
            e.wr  = 1'b1;
            e.id  = 2'(w);
            e.gnt = 4'(1 << w);
            e.dat = pdata[w];
        end
        exp_q.push_back(e);

        wr = e.wr;
        id = w;
        if (e.wr) begin
            model_writes++;
            pdata[w] = 8'($urandom);
        end
        cyc++;
    endtask

    // Monitor: each cycle the DUT presents its outputs, pop the prediction and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant",      e.cyc, 32'(grant),              32'(e.gnt));
                chk("write_req",  e.cyc, 32'(fifo_write_request), 32'(e.wr));
                chk("src_id",     e.cyc, 32'(fifo_src_id),        32'(e.id));
                chk("data_in",    e.cyc, 32'(fifo_data_in),       32'(e.dat));
                chk("busy",       e.cyc, 32'(busy),               32'(e.busy));
                if (fifo_write_request) begin
                    dut_writes++;
                    chk("data_vs_src", e.cyc, 32'(fifo_data_in), 32'(data[fifo_src_id]));
                end
            end
        end
    end

    initial begin
        logic         wr;
        int           id;
        logic [N-1:0] pend;
        int           occ;
        logic         f;

        for (int i = 0; i < N; i++) begin
            pdata[i] = 8'(8'h10 * (i + 1) + i);
            data[i]  = '0;
        end

        // Reset held with all producers requesting, then first arbitration.
        repeat (3) cycle(4'b1111, 1'b0, 1'b1, wr, id);
        // Continuous requests: four-write bursts rotating 0,1,2,3,0.
        repeat (20) cycle(4'b1111, 1'b0, 1'b0, wr, id);

        // Wrap-around: bring the pointer to 3, then only producer 2 requests.
        cycle(4'b1111, 1'b0, 1'b1, wr, id);
        repeat (4) cycle(4'b0100, 1'b0, 1'b0, wr, id);
        repeat (5) cycle(4'b0100, 1'b0, 1'b0, wr, id);
        repeat (2) cycle(4'b0000, 1'b0, 1'b0, wr, id);

        // Full stall mid-burst of producer 1 while producer 3 waits.
        cycle(4'b1010, 1'b0, 1'b1, wr, id);
        repeat (2) cycle(4'b1010, 1'b0, 1'b0, wr, id);
        repeat (3) cycle(4'b1010, 1'b1, 1'b0, wr, id);
        repeat (7) cycle(4'b1010, 1'b0, 1'b0, wr, id);

        // Producer 0 withdraws after one write: bubble, then producer 1.
        cycle(4'b0011, 1'b0, 1'b1, wr, id);
        cycle(4'b0011, 1'b0, 1'b0, wr, id);
        repeat (3) cycle(4'b0010, 1'b0, 1'b0, wr, id);

        // Reset pulsed mid-burst of producer 2.
        repeat (2) cycle(4'b0100, 1'b0, 1'b0, wr, id);
        cycle(4'b1111, 1'b0, 1'b1, wr, id);
        repeat (3) cycle(4'b1111, 1'b0, 1'b0, wr, id);

        // Randomized traffic against a small FIFO with random reads.
        pend = '0;
        occ  = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) pend[i] = ($urandom_range(0, 2) == 0);
                else if ($urandom_range(0, 15) == 0) pend[i] = 1'b0;
            end
            f = (occ >= DEPTH);
            cycle(pend, f, ($urandom_range(0, 249) == 0), wr, id);
            if (wr) begin
                pend[id] = 1'b0;
                occ++;
            end
            if (occ > 0 && $urandom_range(0, 1) == 1) occ--;
        end

        cycle(4'b0000, 1'b0, 1'b0, wr, id);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", cyc, 32'(exp_q.size()), 32'd0);
        chk("write_count", cyc, 32'(dut_writes), 32'(model_writes));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
